// File: rtl/seq_arith_8b_minmax_frame.sv
// Streaming unsigned min/max/count over val/rdy frames delimited by in_last.
// Emits one result per frame; a result handoff may overlap the next frame's first element.
module seq_arith_8b_minmax_frame #(
  parameter int unsigned nbits = 8,
  parameter int unsigned cbits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [nbits-1:0] in_data,
  input  logic             in_last,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [nbits-1:0] out_min,
  output logic [nbits-1:0] out_max,
  output logic [cbits-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [nbits-1:0] min_q, min_d;
  logic [nbits-1:0] max_q, max_d;
  logic [cbits-1:0] cnt_q, cnt_d;
  logic             in_xfer;
  logic             out_xfer;

  // Ready depends only on state and out_rdy, never on in_val.
  assign in_rdy   = (state_q == DONE) ? out_rdy : 1'b1;
  assign out_val  = (state_q == DONE);
  assign in_xfer  = in_val && in_rdy;
  assign out_xfer = out_val && out_rdy;

  assign out_min   = min_q;
  assign out_max   = max_q;
  assign out_count = cnt_q;

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          min_d   = in_data;
          max_d   = in_data;
          cnt_d   = cbits'(1);
          state_d = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_xfer) begin
          if (in_data < min_q) min_d = in_data;
          if (in_data > max_q) max_d = in_data;
          if (cnt_q != '1)     cnt_d = cnt_q + cbits'(1);
          state_d = in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_xfer) begin
          if (in_xfer) begin
            min_d   = in_data;
            max_d   = in_data;
            cnt_d   = cbits'(1);
            state_d = in_last ? DONE : ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      min_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_arith_8b_minmax_frame.sv
// Directed bench for seq_arith_8b_minmax_frame with hand-computed frame results.
module tb_seq_arith_8b_minmax_frame;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out_min;
  logic [7:0] out_max;
  logic [7:0] out_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  seq_arith_8b_minmax_frame #(.nbits(8), .cbits(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_min  (out_min),
    .out_max  (out_max),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [7:0] mn, input logic [7:0] mx,
                         input logic [7:0] cnt);
    chk({tag, "_val"}, {31'd0, out_val}, 32'd1);
    chk({tag, "_min"}, {24'd0, out_min}, {24'd0, mn});
    chk({tag, "_max"}, {24'd0, out_max}, {24'd0, mx});
    chk({tag, "_cnt"}, {24'd0, out_count}, {24'd0, cnt});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_val"}, {31'd0, out_val}, 32'd0);
    chk({tag, "_min"}, {24'd0, out_min}, 32'd0);
    chk({tag, "_max"}, {24'd0, out_max}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, out_count}, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted element; caller guarantees in_rdy is high.
  task automatic send(input logic [7:0] d, input logic last);
    in_val  = 1'b1;
    in_data = d;
    in_last = last;
    tick();
    in_val  = 1'b0;
    in_last = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    in_val  = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_rdy = 1'b1;
    #12;
    chk_zero("reset");
    chk("reset_in_rdy", {31'd0, in_rdy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;

    // Single frame 8,3,200,3(last)
    send(8'd8, 1'b0);
    send(8'd3, 1'b0);
    send(8'd200, 1'b0);
    send(8'd3, 1'b1);
    chk_res("frame1", 8'd3, 8'd200, 8'd4);
    tick();
    chk("frame1_drain", {31'd0, out_val}, 32'd0);

    // Back-to-back single-element frames
    in_val = 1'b1; in_last = 1'b1; in_data = 8'd5;
    chk("b2b_rdy0", {31'd0, in_rdy}, 32'd1);
    tick();
    chk_res("b2b_5", 8'd5, 8'd5, 8'd1);
    in_data = 8'd0;
    chk("b2b_rdy1", {31'd0, in_rdy}, 32'd1);
    tick();
    chk_res("b2b_0", 8'd0, 8'd0, 8'd1);
    in_data = 8'd255;
    chk("b2b_rdy2", {31'd0, in_rdy}, 32'd1);
    tick();
    chk_res("b2b_255", 8'd255, 8'd255, 8'd1);
    in_val = 1'b0; in_last = 1'b0;
    tick();
    chk("b2b_drain", {31'd0, out_val}, 32'd0);

    // Output backpressure, with a pending element offered while stalled
    out_rdy = 1'b0;
    send(8'd10, 1'b0);
    send(8'd20, 1'b1);
    in_val = 1'b1; in_data = 8'd7; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_res("bp_hold", 8'd10, 8'd20, 8'd2);
      chk("bp_in_rdy", {31'd0, in_rdy}, 32'd0);
      tick();
    end
    chk_res("bp_hold_end", 8'd10, 8'd20, 8'd2);
    out_rdy = 1'b1;
    #1;
    chk("bp_in_rdy_up", {31'd0, in_rdy}, 32'd1);
    tick();
    chk_res("bp_next", 8'd7, 8'd7, 8'd1);
    in_val = 1'b0; in_last = 1'b0;
    tick();
    chk("bp_drain", {31'd0, out_val}, 32'd0);

    // Gaps (with garbage on ignored inputs) and extremes
    send(8'd0, 1'b0);
    in_data = 8'd99; in_last = 1'b1;
    tick();
    tick();
    chk("gap_no_val", {31'd0, out_val}, 32'd0);
    send(8'd255, 1'b0);
    send(8'd128, 1'b1);
    chk_res("gap", 8'd0, 8'd255, 8'd3);
    tick();
    chk("gap_drain", {31'd0, out_val}, 32'd0);

    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    send(8'd1, 1'b1);
    chk_res("ties", 8'd1, 8'd1, 8'd3);
    tick();

    // Count saturation
    for (int i = 0; i < 254; i++) send(8'd42, 1'b0);
    chk("sat_254", {24'd0, out_count}, 32'd254);
    for (int i = 0; i < 45; i++) send(8'd42, 1'b0);
    send(8'd42, 1'b1);
    chk_res("sat", 8'd42, 8'd42, 8'd255);
    tick();
    chk("sat_drain", {31'd0, out_val}, 32'd0);

    // Async reset mid-frame
    send(8'd9, 1'b0);
    send(8'd4, 1'b0);
    chk("mid_cnt", {24'd0, out_count}, 32'd2);
    chk("mid_min", {24'd0, out_min}, 32'd4);
    #2 reset = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    #1;

    // Async reset while a result is pending
    out_rdy = 1'b0;
    send(8'd6, 1'b1);
    chk_res("pre_rst_done", 8'd6, 8'd6, 8'd1);
    #2 reset = 1'b0;
    #1;
    chk_zero("rst_done");
    chk("rst_done_rdy", {31'd0, in_rdy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    out_rdy = 1'b1;
    #1;
    send(8'd6, 1'b1);
    chk_res("post_rst", 8'd6, 8'd6, 8'd1);
    tick();
    chk("post_rst_drain", {31'd0, out_val}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
